// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a 2:1 bit-interleaved TDM link, splits frames into channel A/B words
module tdm_demux #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         in_valid,
    input  logic         sync,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         out_valid,
    output logic         err
);
    localparam int IW = $clog2(2 * W);
    localparam logic [IW-1:0] LAST = IW'(2 * W - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  sa_q, sb_q, sa_d, sb_d, a_q, b_q;
    logic          ov_q, err_q;

    // Even frame index feeds channel A, odd feeds channel B, MSB first
    always_comb begin
        sa_d = idx_q[0] ? sa_q : {sa_q[W-2:0], din};
        sb_d = idx_q[0] ? {sb_q[W-2:0], din} : sb_q;
    end

    // Frame FSM: sync always restarts a frame; a sync inside a frame is an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            idx_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ov_q  <= 1'b0;
            err_q <= 1'b0;
            if (in_valid) begin
                if (sync) begin
                    state_q <= RECV;
                    idx_q   <= IW'(1);
                    sa_q    <= {{(W-1){1'b0}}, din};
                    sb_q    <= '0;
                    err_q   <= (state_q == RECV);
                end else if (state_q == RECV) begin
                    if (idx_q == LAST) begin
                        a_q     <= sa_d;
                        b_q     <= sb_d;
                        ov_q    <= 1'b1;
                        state_q <= HUNT;
                        idx_q   <= '0;
                        sa_q    <= '0;
                        sb_q    <= '0;
                    end else begin
                        sa_q  <= sa_d;
                        sb_q  <= sb_d;
                        idx_q <= idx_q + IW'(1);
                    end
                end
            end
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign out_valid = ov_q;
    assign err       = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed frames with hand-computed words and pulse timing
module tb_tdm_demux;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       din = 1'b0;
    logic       in_valid = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] a_out, b_out;
    logic       out_valid, err;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    int ov_cyc[16];
    logic [7:0] a_cap[16];
    logic [7:0] b_cap[16];
    int o, e, t0, t1, t2;

    tdm_demux #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .sync(sync),
        .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter stepping on each active edge
    always @(posedge clk) cyc++;

    // Record every output pulse away from the active edge
    always @(negedge clk) begin
        if (out_valid) begin
            if (ov_cnt < 16) begin
                ov_cyc[ov_cnt] = cyc;
                a_cap[ov_cnt] = a_out;
                b_cap[ov_cnt] = b_out;
            end
            ov_cnt++;
        end
        if (err) begin
            err_cyc = cyc;
            err_cnt++;
        end
        if (out_valid && err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            sync = 1'b0;
        end
    endtask

    // Drive n interleaved bits of words a/b; optional stall after bit stall_at
    task automatic send(input logic [7:0] a, input logic [7:0] b, input int n, input logic sy,
                        input int stall_at, input int stall_n, output int ts);
        ts = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) ts = cyc;
            din = (k % 2 == 0) ? a[7 - (k % 16) / 2] : b[7 - (k % 16) / 2];
            sync = (k == 0) && sy;
            in_valid = 1'b1;
            if (k == stall_at)
                for (int j = 0; j < stall_n; j++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    sync = 1'b0;
                end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_a", 16'(a_out), 16'h00);
        chk("rst_b", 16'(b_out), 16'h00);
        chk("rst_ov", 16'(out_valid), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        o = ov_cnt; e = err_cnt;
        send(8'hA5, 8'h3C, 16, 1'b1, -1, 0, t0);
        idle(3);
        chk("basic_ovn", 16'(ov_cnt - o), 16'd1);
        chk("basic_errn", 16'(err_cnt - e), 16'd0);
        chk("basic_lat", 16'(ov_cyc[o] - t0), 16'd16);
        chk("basic_a", 16'(a_cap[o]), 16'hA5);
        chk("basic_b", 16'(b_cap[o]), 16'h3C);

        o = ov_cnt; e = err_cnt;
        send(8'hA5, 8'h3C, 16, 1'b1, 5, 3, t0);
        idle(3);
        chk("stall_ovn", 16'(ov_cnt - o), 16'd1);
        chk("stall_errn", 16'(err_cnt - e), 16'd0);
        chk("stall_lat", 16'(ov_cyc[o] - t0), 16'd19);
        chk("stall_a", 16'(a_cap[o]), 16'hA5);
        chk("stall_b", 16'(b_cap[o]), 16'h3C);

        o = ov_cnt; e = err_cnt;
        send(8'h00, 8'hFF, 6, 1'b1, -1, 0, t1);
        send(8'hFF, 8'h00, 16, 1'b1, -1, 0, t2);
        idle(3);
        chk("resync_errn", 16'(err_cnt - e), 16'd1);
        chk("resync_errcyc", 16'(err_cyc - t2), 16'd1);
        chk("resync_ovn", 16'(ov_cnt - o), 16'd1);
        chk("resync_lat", 16'(ov_cyc[o] - t2), 16'd16);
        chk("resync_a", 16'(a_cap[o]), 16'hFF);
        chk("resync_b", 16'(b_cap[o]), 16'h00);

        o = ov_cnt; e = err_cnt;
        send(8'h12, 8'h34, 16, 1'b1, -1, 0, t1);
        send(8'h56, 8'h78, 16, 1'b1, -1, 0, t2);
        idle(3);
        chk("b2b_ovn", 16'(ov_cnt - o), 16'd2);
        chk("b2b_errn", 16'(err_cnt - e), 16'd0);
        chk("b2b_gap", 16'(ov_cyc[o + 1] - ov_cyc[o]), 16'd16);
        chk("b2b_a0", 16'(a_cap[o]), 16'h12);
        chk("b2b_b0", 16'(b_cap[o]), 16'h34);
        chk("b2b_a1", 16'(a_cap[o + 1]), 16'h56);
        chk("b2b_b1", 16'(b_cap[o + 1]), 16'h78);

        o = ov_cnt; e = err_cnt;
        send(8'hC3, 8'h5A, 9, 1'b1, -1, 0, t0);
        chk("hold_a", 16'(a_out), 16'h56);
        chk("hold_b", 16'(b_out), 16'h78);
        @(negedge clk);
        din = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_a", 16'(a_out), 16'h00);
        chk("arst_b", 16'(b_out), 16'h00);
        chk("arst_ov", 16'(out_valid), 16'h0);
        chk("arst_err", 16'(err), 16'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        send(8'hFF, 8'hFF, 20, 1'b0, -1, 0, t1);
        idle(3);
        chk("nosync_ovn", 16'(ov_cnt - o), 16'd0);
        chk("nosync_errn", 16'(err_cnt - e), 16'd0);
        chk("nosync_a", 16'(a_out), 16'h00);
        chk("nosync_b", 16'(b_out), 16'h00);
        send(8'hC3, 8'h5A, 16, 1'b1, -1, 0, t2);
        idle(3);
        chk("post_ovn", 16'(ov_cnt - o), 16'd1);
        chk("post_a", 16'(a_out), 16'hC3);
        chk("post_b", 16'(b_out), 16'h5A);
        chk("post_lat", 16'(ov_cyc[o] - t2), 16'd16);
        chk("never_both", 16'(both_cnt), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
